// File: rtl/counter_step_driver_pkg.sv
// Shared definitions for the counter strobe driver and the host command decoder.
// Latency: n/a (types, encodings and an elaboration-time helper only).
// Backpressure: n/a.
package counter_step_driver_pkg;

    // Host command encodings on cmd_op.
    typedef enum logic [1:0] {
        OP_SEEK  = 2'b00,
        OP_RESET = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } cmd_op_e;

    // Driver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAN   = 3'd1,
        ST_STROBE = 3'd2,
        ST_GAP    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_CHECK  = 3'd5
    } state_e;

    // Which strobe line a command drives.
    typedef enum logic [1:0] {
        STB_UP   = 2'd0,
        STB_DOWN = 2'd1,
        STB_CLR  = 2'd2
    } strobe_e;

    // Width of the shared pacing counter: it must hold max(PACE-1, SETTLE).
    // Kept at two bits minimum so the "remaining <= 1" test is a plain slice.
    function automatic int pacer_width(input int pace, input int settle);
        int m;
        int w;
        m = (pace > settle) ? pace : settle;
        w = $clog2(m + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/counter_step_driver_step_pacer.sv
// Loadable down-counter that times the inter-strobe gap and the settle window.
// Latency: last_o rises in the last cycle of a loaded window of load_val_i cycles.
// Backpressure: none; the owner simply ignores last_o when not waiting.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      start a new window (overrides any window in progress)
//   load_val_i  window length in cycles, counted from the cycle after load_i
//   last_o      high while the remaining count is 1 (or the counter is idle at 0)
module counter_step_driver_step_pacer #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          last_o
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Remaining count of 0 or 1: the current cycle is the last of the window.
    assign last_o = (cnt_q[CW-1:1] == '0);

endmodule

// File: rtl/counter_step_driver.sv
// Host-side initiator that plans and emits paced up/down/clear strobes to a counter, then verifies its readback.
// Latency: UP/DOWN N>0 finishes (done) 3+(N-1)*PACE+SETTLE cycles after the accept cycle; 0 steps in SETTLE+2.
// Backpressure: cmd_ready is high only in IDLE; one command in flight, nothing is queued.
//
// Ports:
//   sys_clk, reset_n       clock and asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_op selects SEEK/RESET/UP/DOWN, cmd_value is target or N
//   abort                  cancels the command in progress (ignored in IDLE)
//   count_in               counter readback
//   up/down/reset_pulse    one-cycle strobes to the counter, mutually exclusive
//   busy, done, err        status; err qualifies the done cycle (mismatch or abort)
//   exp_count              value the counter should hold once the command completes
module counter_step_driver
    import counter_step_driver_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PACE   = 16,
    parameter int SETTLE = 2
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic             abort,
    input  logic [WIDTH-1:0] count_in,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             reset_pulse,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] exp_count
);

    localparam int             CW          = pacer_width(PACE, SETTLE);
    localparam logic [CW-1:0]  GAP_LOAD    = CW'(PACE - 1);
    localparam logic [CW-1:0]  SETTLE_LOAD = CW'(SETTLE);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    // Half the counter range; a SEEK distance of exactly this goes up.
    localparam logic [WIDTH-1:0] HALF      = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q;
    cmd_op_e          op_q;
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] steps_q;      // strobes still to issue after the current one
    logic [WIDTH-1:0] exp_q;
    strobe_e          kind_q;
    logic             aborted_q;
    logic             cmd_ready_q;
    logic             up_q;
    logic             down_q;
    logic             clr_q;

    // ------------------------------------------------------------------
    // Planner: evaluated combinationally while in PLAN, using the live
    // readback so the plan reflects where the counter actually is.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] seek_diff;
    logic [WIDTH-1:0] steps_d;
    logic [WIDTH-1:0] exp_d;
    strobe_e          kind_d;

    always_comb begin
        seek_diff = val_q - count_in;
        steps_d   = '0;
        exp_d     = '0;
        kind_d    = STB_UP;
        case (op_q)
            OP_SEEK: begin
                exp_d = val_q;
                // Shortest direction around the ring; d==0 yields zero steps.
                if (seek_diff <= HALF) begin
                    steps_d = seek_diff;
                    kind_d  = STB_UP;
                end else begin
                    steps_d = '0 - seek_diff;
                    kind_d  = STB_DOWN;
                end
            end
            OP_RESET: begin
                steps_d = ONE;
                exp_d   = '0;
                kind_d  = STB_CLR;
            end
            OP_UP: begin
                steps_d = val_q;
                exp_d   = count_in + val_q;
                kind_d  = STB_UP;
            end
            OP_DOWN: begin
                steps_d = val_q;
                exp_d   = count_in - val_q;
                kind_d  = STB_DOWN;
            end
            default: begin
                steps_d = '0;
                exp_d   = '0;
                kind_d  = STB_UP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pacing: one counter serves both the inter-strobe gap and the settle
    // window, since the two never overlap.
    // ------------------------------------------------------------------
    logic          in_busy;
    logic          abort_hit;
    logic          pace_last;
    logic          gap_load;
    logic          settle_load;
    logic          pace_load;
    logic [CW-1:0] pace_val;
    logic          fire_d;
    strobe_e       fire_kind;

    assign in_busy   = (state_q != ST_IDLE);
    // Abort in CHECK is folded into err for that same done cycle instead.
    assign abort_hit = abort && in_busy && (state_q != ST_CHECK);

    assign gap_load    = (state_q == ST_STROBE) && (steps_q != '0);
    assign settle_load = ((state_q == ST_PLAN)   && (steps_d == '0)) ||
                         ((state_q == ST_STROBE) && (steps_q == '0));
    assign pace_load   = gap_load || settle_load;
    assign pace_val    = gap_load ? GAP_LOAD : SETTLE_LOAD;

    counter_step_driver_step_pacer #(
        .CW(CW)
    ) u_step_pacer (
        .clk_i      (sys_clk),
        .rst_ni     (reset_n),
        .load_i     (pace_load),
        .load_val_i (pace_val),
        .last_o     (pace_last)
    );

    // A strobe is issued on every entry into STROBE; abort suppresses it.
    always_comb begin
        fire_d = 1'b0;
        if (!abort) begin
            case (state_q)
                ST_PLAN:   fire_d = (steps_d != '0);
                ST_STROBE: fire_d = (steps_q != '0) && (PACE == 1);
                ST_GAP:    fire_d = pace_last;
                default:   fire_d = 1'b0;
            endcase
        end
    end

    assign fire_kind = (state_q == ST_PLAN) ? kind_d : kind_q;

    // ------------------------------------------------------------------
    // FSM with registered strobes and handshake ready
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SEEK;
            val_q       <= '0;
            steps_q     <= '0;
            exp_q       <= '0;
            kind_q      <= STB_UP;
            aborted_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            up_q   <= fire_d && (fire_kind == STB_UP);
            down_q <= fire_d && (fire_kind == STB_DOWN);
            clr_q  <= fire_d && (fire_kind == STB_CLR);

            if (abort_hit) begin
                state_q     <= ST_CHECK;
                aborted_q   <= 1'b1;
                cmd_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_valid && cmd_ready_q) begin
                            op_q        <= cmd_op_e'(cmd_op);
                            val_q       <= cmd_value;
                            state_q     <= ST_PLAN;
                            cmd_ready_q <= 1'b0;
                        end else begin
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    ST_PLAN: begin
                        exp_q  <= exp_d;
                        kind_q <= kind_d;
                        if (steps_d == '0) begin
                            state_q <= ST_SETTLE;
                        end else begin
                            steps_q <= steps_d - ONE;
                            state_q <= ST_STROBE;
                        end
                    end
                    ST_STROBE: begin
                        if (steps_q == '0) begin
                            state_q <= ST_SETTLE;
                        end else if (PACE == 1) begin
                            steps_q <= steps_q - ONE;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (pace_last) begin
                            steps_q <= steps_q - ONE;
                            state_q <= ST_STROBE;
                        end
                    end
                    ST_SETTLE: begin
                        if (pace_last) begin
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        state_q     <= ST_IDLE;
                        aborted_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. done/err are decoded from CHECK so that an abort arriving
    // in the CHECK cycle itself still forces err.
    // ------------------------------------------------------------------
    assign cmd_ready   = cmd_ready_q;
    assign up_pulse    = up_q;
    assign down_pulse  = down_q;
    assign reset_pulse = clr_q;
    assign busy        = in_busy;
    assign done        = (state_q == ST_CHECK);
    assign err         = done && (aborted_q || abort || (count_in != exp_q));
    assign exp_count   = exp_q;

endmodule

// File: tb/tb_counter_step_driver.sv
module tb_counter_step_driver;

    localparam int W      = 8;
    localparam int PACE   = 4;
    localparam int SETTLE = 2;

    logic         sys_clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_value;
    logic         abort;
    logic [W-1:0] count_in;
    logic         up_pulse;
    logic         down_pulse;
    logic         reset_pulse;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] exp_count;

    int checks = 0;
    int fails  = 0;

    // Behavioural counter under test-bench control.
    logic [W-1:0] model_cnt;
    logic         model_hold;
    logic         model_ld;
    logic [W-1:0] model_ld_val;

    typedef struct {
        int         n_up;
        int         n_dn;
        int         n_rs;
        int         done_k;
        int         bad_gap;
        int         excl_bad;
        int         acks;
        int         post_evt;
        logic       err_v;
        logic       rdy_after;
        logic [7:0] exp_v;
    } res_t;

    counter_step_driver #(.WIDTH(W), .PACE(PACE), .SETTLE(SETTLE)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_value   (cmd_value),
        .abort       (abort),
        .count_in    (count_in),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .reset_pulse (reset_pulse),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .exp_count   (exp_count)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (model_ld)
            model_cnt <= model_ld_val;
        else if (!model_hold) begin
            if (reset_pulse)     model_cnt <= '0;
            else if (up_pulse)   model_cnt <= model_cnt + 8'd1;
            else if (down_pulse) model_cnt <= model_cnt - 8'd1;
        end
    end
    assign count_in = model_cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load_count(input logic [7:0] v);
        model_ld     = 1'b1;
        model_ld_val = v;
        @(negedge sys_clk);
        model_ld     = 1'b0;
    endtask

    // Issue one command and observe until done (k = cycles after the accept cycle).
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] val, input int budget,
                           input bit keep_valid, input int abort_after, output res_t r);
        int  last;
        int  nst;
        bit  aborted;
        r.n_up = 0; r.n_dn = 0; r.n_rs = 0; r.done_k = -1; r.bad_gap = 0;
        r.excl_bad = 0; r.acks = 0; r.post_evt = 0; r.err_v = 1'bx;
        r.rdy_after = 1'bx; r.exp_v = 'x;
        last = 0;
        aborted = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_value = val;
        for (int k = 1; k <= budget; k++) begin
            @(negedge sys_clk);
            nst = int'(up_pulse) + int'(down_pulse) + int'(reset_pulse);
            if (nst > 1) r.excl_bad++;
            if (nst > 0) begin
                if (last != 0 && (k - last) != PACE) r.bad_gap++;
                last = k;
            end
            r.n_up += int'(up_pulse);
            r.n_dn += int'(down_pulse);
            r.n_rs += int'(reset_pulse);
            if (cmd_ready) r.acks++;
            if (!keep_valid) cmd_valid = 1'b0;
            abort = 1'b0;
            if (done) begin
                r.done_k = k;
                r.err_v  = err;
                r.exp_v  = exp_count;
                break;
            end
            if (abort_after > 0 && !aborted && r.n_up == abort_after) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge sys_clk);
        r.rdy_after = cmd_ready;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge sys_clk);
            r.post_evt += int'(up_pulse) + int'(down_pulse) + int'(reset_pulse) + int'(done);
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if ({up_pulse, down_pulse, reset_pulse} !== 3'b000)
            begin fails++; $display("FAIL rst_strobes: got %b want 000", {up_pulse, down_pulse, reset_pulse}); end
        checks++; if (exp_count !== 8'h00) begin fails++; $display("FAIL rst_exp: got %h want 00", exp_count); end
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_strobe();
        bit seen;
        int evt;
        load_count(8'h00);
        seen = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_value = 8'd10;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge sys_clk);
            cmd_valid = 1'b0;
            if (up_pulse) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("FAIL mid_strobe_seen: got %b want 1", seen); end
        reset_n = 1'b0;
        #1;
        checks++; if ({up_pulse, down_pulse, reset_pulse, busy, done, cmd_ready} !== 6'b0)
            begin fails++; $display("FAIL mid_rst_outputs: got %b want 000000",
                                    {up_pulse, down_pulse, reset_pulse, busy, done, cmd_ready}); end
        checks++; if (exp_count !== 8'h00) begin fails++; $display("FAIL mid_rst_exp: got %h want 00", exp_count); end
        @(negedge sys_clk);
        reset_n = 1'b1;
        evt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            evt += int'(done) + int'(up_pulse) + int'(down_pulse) + int'(reset_pulse);
        end
        checks++; if (evt !== 0) begin fails++; $display("FAIL mid_rst_no_done: got %0d events want 0", evt); end
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_seek_up();
        res_t r;
        load_count(8'h10);
        run_cmd(2'b00, 8'h13, 60, 1'b0, 0, r);
        checks++; if (r.n_up !== 3 || r.n_dn !== 0) begin fails++; $display("FAIL seek_up_count: got up=%0d dn=%0d want 3/0", r.n_up, r.n_dn); end
        checks++; if (r.bad_gap !== 0)  begin fails++; $display("FAIL seek_up_pace: got %0d bad gaps want 0", r.bad_gap); end
        checks++; if (r.done_k !== 13)  begin fails++; $display("FAIL seek_up_latency: got %0d want 13", r.done_k); end
        checks++; if (r.err_v !== 1'b0) begin fails++; $display("FAIL seek_up_err: got %b want 0", r.err_v); end
        checks++; if (r.exp_v !== 8'h13) begin fails++; $display("FAIL seek_up_exp: got %h want 13", r.exp_v); end
        checks++; if (r.acks !== 0 || r.rdy_after !== 1'b1)
            begin fails++; $display("FAIL seek_up_ready: got busy_rdy=%0d after=%b want 0/1", r.acks, r.rdy_after); end
    endtask

    task automatic test_seek_wrap();
        res_t r;
        load_count(8'h02);
        run_cmd(2'b00, 8'hFE, 60, 1'b0, 0, r);
        checks++; if (r.n_dn !== 4 || r.n_up !== 0) begin fails++; $display("FAIL wrap_count: got dn=%0d up=%0d want 4/0", r.n_dn, r.n_up); end
        checks++; if (r.done_k !== 17 || r.err_v !== 1'b0)
            begin fails++; $display("FAIL wrap_done: got k=%0d err=%b want 17/0", r.done_k, r.err_v); end
        checks++; if (r.exp_v !== 8'hFE) begin fails++; $display("FAIL wrap_exp: got %h want fe", r.exp_v); end
        load_count(8'h00);
        run_cmd(2'b00, 8'h80, 700, 1'b0, 0, r);
        checks++; if (r.n_up !== 128 || r.n_dn !== 0) begin fails++; $display("FAIL tie_count: got up=%0d dn=%0d want 128/0", r.n_up, r.n_dn); end
        checks++; if (r.done_k !== 513 || r.err_v !== 1'b0)
            begin fails++; $display("FAIL tie_done: got k=%0d err=%b want 513/0", r.done_k, r.err_v); end
        checks++; if (r.excl_bad !== 0 || r.bad_gap !== 0)
            begin fails++; $display("FAIL tie_shape: got excl=%0d gap=%0d want 0/0", r.excl_bad, r.bad_gap); end
    endtask

    task automatic test_zero_steps();
        res_t r;
        load_count(8'h55);
        run_cmd(2'b10, 8'h00, 20, 1'b0, 0, r);
        checks++; if (r.n_up + r.n_dn + r.n_rs !== 0) begin fails++; $display("FAIL up0_strobes: got %0d want 0", r.n_up + r.n_dn + r.n_rs); end
        checks++; if (r.done_k !== SETTLE + 2 || r.err_v !== 1'b0)
            begin fails++; $display("FAIL up0_done: got k=%0d err=%b want 4/0", r.done_k, r.err_v); end
        run_cmd(2'b00, 8'h55, 20, 1'b0, 0, r);
        checks++; if (r.n_up + r.n_dn + r.n_rs !== 0) begin fails++; $display("FAIL seek0_strobes: got %0d want 0", r.n_up + r.n_dn + r.n_rs); end
        checks++; if (r.done_k !== 4 || r.err_v !== 1'b0 || r.exp_v !== 8'h55)
            begin fails++; $display("FAIL seek0_done: got k=%0d err=%b exp=%h want 4/0/55", r.done_k, r.err_v, r.exp_v); end
    endtask

    task automatic test_reset_cmd();
        res_t r;
        load_count(8'h33);
        run_cmd(2'b01, 8'hAA, 20, 1'b0, 0, r);
        checks++; if (r.n_rs !== 1 || r.n_up + r.n_dn !== 0)
            begin fails++; $display("FAIL clr_count: got rs=%0d other=%0d want 1/0", r.n_rs, r.n_up + r.n_dn); end
        checks++; if (r.done_k !== 5 || r.err_v !== 1'b0 || r.exp_v !== 8'h00)
            begin fails++; $display("FAIL clr_done: got k=%0d err=%b exp=%h want 5/0/00", r.done_k, r.err_v, r.exp_v); end
    endtask

    task automatic test_down_mismatch();
        res_t r;
        model_hold = 1'b1;
        load_count(8'h20);
        run_cmd(2'b11, 8'd5, 60, 1'b0, 0, r);
        model_hold = 1'b0;
        checks++; if (r.n_dn !== 5 || r.n_up !== 0) begin fails++; $display("FAIL hold_count: got dn=%0d up=%0d want 5/0", r.n_dn, r.n_up); end
        checks++; if (r.done_k !== 21 || r.err_v !== 1'b1)
            begin fails++; $display("FAIL hold_done: got k=%0d err=%b want 21/1", r.done_k, r.err_v); end
        checks++; if (r.exp_v !== 8'h1B) begin fails++; $display("FAIL hold_exp: got %h want 1b", r.exp_v); end
    endtask

    task automatic test_abort();
        res_t r;
        load_count(8'h00);
        run_cmd(2'b10, 8'd10, 80, 1'b1, 3, r);
        checks++; if (r.n_up !== 3) begin fails++; $display("FAIL abort_strobes: got %0d want 3", r.n_up); end
        checks++; if (r.done_k !== 11 || r.err_v !== 1'b1)
            begin fails++; $display("FAIL abort_done: got k=%0d err=%b want 11/1", r.done_k, r.err_v); end
        checks++; if (r.acks !== 0) begin fails++; $display("FAIL abort_busy_ack: got %0d ready cycles want 0", r.acks); end
        checks++; if (r.post_evt !== 0 || r.rdy_after !== 1'b1)
            begin fails++; $display("FAIL abort_after: got evt=%0d rdy=%b want 0/1", r.post_evt, r.rdy_after); end
    endtask

    task automatic test_abort_idle();
        res_t r;
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
            begin fails++; $display("FAIL idle_abort: got done=%b busy=%b rdy=%b want 0/0/1", done, busy, cmd_ready); end
        load_count(8'h40);
        run_cmd(2'b10, 8'd2, 40, 1'b0, 0, r);
        checks++; if (r.n_up !== 2 || r.done_k !== 9 || r.err_v !== 1'b0 || r.exp_v !== 8'h42)
            begin fails++; $display("FAIL idle_abort_next: got up=%0d k=%0d err=%b exp=%h want 2/9/0/42",
                                    r.n_up, r.done_k, r.err_v, r.exp_v); end
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_value    = '0;
        abort        = 1'b0;
        model_hold   = 1'b0;
        model_ld     = 1'b1;
        model_ld_val = '0;
        repeat (3) @(negedge sys_clk);
        model_ld = 1'b0;
        test_reset();
        test_reset_mid_strobe();
        test_seek_up();
        test_seek_wrap();
        test_zero_steps();
        test_reset_cmd();
        test_down_mismatch();
        test_abort();
        test_abort_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
